// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transceiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam int unsigned CLOCKS_PER_BIT_DEFAULT = 50;
    localparam int unsigned DATA_BITS              = 8;
    localparam int unsigned BIT_IDX_W              = $clog2(DATA_BITS);

    // Width of a counter that spans 0..cpb-1.
    function automatic int unsigned cnt_width(input int unsigned cpb);
        return (cpb < 2) ? 1 : $clog2(cpb);
    endfunction

    localparam int unsigned CNT_W_DEFAULT = cnt_width(CLOCKS_PER_BIT_DEFAULT);

endpackage

// File: rtl/uart_receiver.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling, glitch and framing-error rejection.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = CLOCKS_PER_BIT_DEFAULT
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       rx_serial_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o
);

    localparam int unsigned CNT_W = cnt_width(CLOCKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(DATA_BITS - 1);

    logic [1:0]           sync_q;
    logic                 rx_prev_q;
    uart_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIT_IDX_W-1:0] bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 rx_valid_q;
    logic [7:0]           rx_data_q;
    logic                 rx_s;

    assign rx_s       = sync_q[1];
    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;

    // Falling edge of the synchronized line arms the frame; a framing error
    // leaves rx_prev_q low, so the next start waits for the line to go high.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q     <= 2'b11;
            rx_prev_q  <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
        end else begin
            sync_q     <= {sync_q[0], rx_serial_i};
            rx_prev_q  <= rx_s;
            rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (rx_prev_q && !rx_s) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        state_q <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == IDX_LAST) begin
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + BIT_IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        if (rx_s) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: inline transmitter plus the uart_receiver sub-module.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = CLOCKS_PER_BIT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       UART_RX,
    output logic       UART_TX,
    output logic       rx_complete,
    output logic [7:0] rx_data,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_complete
);

    localparam int unsigned CNT_W = cnt_width(CLOCKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(DATA_BITS - 1);

    uart_state_e          tx_state_q;
    logic [CNT_W-1:0]     tx_cnt_q;
    logic [BIT_IDX_W-1:0] tx_bit_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic                 tx_line_q;
    logic                 tx_complete_q;

    assign UART_TX     = tx_line_q;
    assign tx_complete = tx_complete_q;

    // Line and ready flag change on the same edge as the state, so the start
    // bit begins at acceptance and ready returns exactly ten bit times later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state_q    <= IDLE;
            tx_cnt_q      <= '0;
            tx_bit_q      <= '0;
            tx_shift_q    <= '0;
            tx_line_q     <= 1'b1;
            tx_complete_q <= 1'b1;
        end else begin
            case (tx_state_q)
                IDLE: begin
                    tx_cnt_q <= '0;
                    if (tx_valid) begin
                        tx_shift_q    <= tx_data;
                        tx_line_q     <= 1'b0;
                        tx_complete_q <= 1'b0;
                        tx_state_q    <= START;
                    end
                end
                START: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_line_q  <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_state_q <= DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == IDX_LAST) begin
                            tx_line_q  <= 1'b1;
                            tx_state_q <= STOP;
                        end else begin
                            tx_bit_q   <= tx_bit_q + BIT_IDX_W'(1);
                            tx_line_q  <= tx_shift_q[0];
                            tx_shift_q <= tx_shift_q >> 1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q      <= '0;
                        tx_complete_q <= 1'b1;
                        tx_state_q    <= IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                default: tx_state_q <= IDLE;
            endcase
        end
    end

    uart_receiver #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_rx (
        .clock_i    (clock),
        .reset_i    (reset),
        .rx_serial_i(UART_RX),
        .rx_valid_o (rx_complete),
        .rx_data_o  (rx_data)
    );

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed plus randomized bench for uart_transceiver against a frame-level reference model.
module tb_uart_transceiver;

    localparam int CPB = 50;

    logic       clock;
    logic       reset;
    logic       UART_RX;
    logic       UART_TX;
    logic       rx_complete;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_complete;

    logic loop_en;
    logic rx_drv;

    int n_cmp;
    int n_err;

    logic [7:0] rx_got[$];
    logic [7:0] exp_q[$];

    assign UART_RX = loop_en ? UART_TX : rx_drv;

    uart_transceiver #(
        .CLOCKS_PER_BIT(CPB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .UART_RX    (UART_RX),
        .UART_TX    (UART_TX),
        .rx_complete(rx_complete),
        .rx_data    (rx_data),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_complete(tx_complete)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Every received strobe is logged; a strobe wider than one cycle logs twice.
    always @(negedge clock) begin
        if (rx_complete === 1'b1) rx_got.push_back(rx_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_count"}, 32'(rx_got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_got.size(); i++) begin
            check({tag, "_byte"}, 32'(rx_got[i]), 32'(exp_q[i]));
        end
        rx_got.delete();
        exp_q.delete();
    endtask

    task automatic wait_txc(input logic level, input int limit, input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (tx_complete !== level && k < limit);
        check(tag, 32'(tx_complete), 32'(level));
    endtask

    // Sends one byte and samples UART_TX at every bit mid-point after acceptance.
    task automatic send_tx_check(input logic [7:0] d, input int hold, input string tag);
        logic [9:0] frame;
        logic [9:0] seen;
        int         low_cnt;
        int         bad_idle;
        frame   = {1'b1, d, 1'b0};
        seen    = '0;
        low_cnt = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 1; i <= 10 * CPB + 1; i++) begin
            @(negedge clock);
            if (i == hold) tx_valid = 1'b0;
            if (tx_complete !== 1'b1) low_cnt++;
            if (i <= 10 * CPB && (i - 1) % CPB == CPB / 2) seen[(i - 1) / CPB] = UART_TX;
        end
        check({tag, "_frame"}, 32'(seen), 32'(frame));
        check({tag, "_busy_cycles"}, 32'(low_cnt), 32'(10 * CPB));
        bad_idle = 0;
        for (int i = 0; i < 2 * CPB; i++) begin
            @(negedge clock);
            if (tx_complete !== 1'b1 || UART_TX !== 1'b1) bad_idle++;
        end
        check({tag, "_single_frame"}, 32'(bad_idle), 32'd0);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop, input int len);
        logic [9:0] frame;
        frame = {stop, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx_drv = frame[k];
            repeat (len) @(negedge clock);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        logic [7:0] b2b[3];
        logic [7:0] r;
        int         bad;
        int         len;
        n_cmp    = 0;
        n_err    = 0;
        loop_en  = 1'b0;
        rx_drv   = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        reset    = 1'b1;

        idle(3);
        check("rst_tx", 32'(UART_TX), 32'd1);
        check("rst_txc", 32'(tx_complete), 32'd1);
        check("rst_rxc", 32'(rx_complete), 32'd0);
        check("rst_rxd", 32'(rx_data), 32'h00);
        reset = 1'b0;

        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (UART_TX !== 1'b1 || tx_complete !== 1'b1) bad++;
        end
        check("idle_lines", 32'(bad), 32'd0);
        check("idle_rxd", 32'(rx_data), 32'h00);
        check_rx("idle_rx");

        send_tx_check(8'hA5, 2, "tx_a5");

        loop_en = 1'b1;
        b2b[0] = 8'h00;
        b2b[1] = 8'hFF;
        b2b[2] = 8'h3C;
        tx_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tx_data = b2b[j];
            exp_q.push_back(b2b[j]);
            wait_txc(1'b0, 5, "b2b_accept");
            if (j == 2) tx_valid = 1'b0;
            wait_txc(1'b1, 10 * CPB + 5, "b2b_done");
        end
        idle(CPB);
        check_rx("b2b_rx");
        loop_en = 1'b0;

        rx_drv = 1'b0;
        idle(10);
        rx_drv = 1'b1;
        idle(2 * CPB);
        check_rx("glitch_rx");
        drive_frame(8'h55, 1'b1, CPB);
        exp_q.push_back(8'h55);
        idle(CPB);
        check_rx("after_glitch_rx");

        drive_frame(8'h12, 1'b0, CPB);
        idle(2 * CPB);
        check_rx("ferr_rx");
        check("ferr_hold", 32'(rx_data), 32'h55);
        drive_frame(8'h34, 1'b1, CPB);
        exp_q.push_back(8'h34);
        idle(CPB);
        check_rx("after_ferr_rx");
        check("after_ferr_rxd", 32'(rx_data), 32'h34);

        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        idle(1);
        tx_valid = 1'b0;
        idle(200);
        check("c3_mid_bit", 32'(UART_TX), 32'd0);
        check("c3_busy", 32'(tx_complete), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("abort_tx", 32'(UART_TX), 32'd1);
        check("abort_txc", 32'(tx_complete), 32'd1);
        idle(2);
        reset = 1'b0;
        idle(2);
        rx_got.delete();
        send_tx_check(8'h7E, 1, "tx_7e");

        loop_en = 1'b1;
        for (int j = 0; j < 4; j++) begin
            r = 8'($urandom);
            exp_q.push_back(r);
            send_tx_check(r, int'($urandom_range(1, 5)), "rand_loop");
            check_rx("rand_loop_rx");
        end
        loop_en = 1'b0;

        for (int j = 0; j < 6; j++) begin
            r   = 8'($urandom);
            len = int'($urandom_range(CPB - 1, CPB + 1));
            drive_frame(r, 1'b1, len);
            exp_q.push_back(r);
            idle(int'($urandom_range(0, 20)));
        end
        idle(CPB);
        check_rx("rand_rx");
        check("rand_rxd_last", 32'(rx_data), 32'(r));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
